// File: rtl/array_eyeriss_feeder_pkg.sv
// Shared types and geometry helpers for the Eyeriss array feeder.
//   feeder_state_e : pass-level FSM states
//   drain_len()    : cycles needed to flush the longest skew line
//   out_len()      : cycles for the diagonal ofm drain to reach the last column
//   data_t         : signed ifm/weight word at the default width
package array_eyeriss_pkg;

  localparam int HEIGHT_DEF = 12;
  localparam int WIDTH_DEF  = 14;
  localparam int IWIDTH_DEF = 16;
  localparam int CWIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_W,
    STREAM,
    DRAIN,
    OUT,
    DONE
  } feeder_state_e;

  typedef logic signed [IWIDTH_DEF-1:0] data_t;

  // DRAIN_LEN = max(HEIGHT, WIDTH) + 1
  function automatic int drain_len(input int h, input int w);
    return ((h > w) ? h : w) + 1;
  endfunction

  // OUT_LEN = HEIGHT + WIDTH - 1
  function automatic int out_len(input int h, input int w);
    return h + w - 1;
  endfunction

endpackage

// File: rtl/array_eyeriss_feeder_skew.sv
// skew_line: DEPTH-stage delay line carrying {en, clr, data}.
//   clk, rst_n          : clock, async active-low reset
//   en_in/clr_in/data_in: root injection
//   en_out/clr_out/data_out: injection delayed DEPTH cycles
// Data stages only load when the token entering them has en=1, so bubbles
// and clear tokens leave the last delivered word in place.
// DEPTH=0 is a plain wire; DWIDTH=0 still carries one dummy data bit.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DWIDTH = 16,
  localparam int DW    = (DWIDTH > 0) ? DWIDTH : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_in,
  input  logic          clr_in,
  input  logic [DW-1:0] data_in,
  output logic          en_out,
  output logic          clr_out,
  output logic [DW-1:0] data_out
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign en_out   = en_in;
    assign clr_out  = clr_in;
    assign data_out = data_in;
  end else begin : g_pipe
    logic [DEPTH-1:0]         en_q;
    logic [DEPTH-1:0]         clr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q   <= '0;
        clr_q  <= '0;
        data_q <= '0;
      end else begin
        en_q[0]  <= en_in;
        clr_q[0] <= clr_in;
        if (en_in) data_q[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) begin
          en_q[i]  <= en_q[i-1];
          clr_q[i] <= clr_q[i-1];
          if (en_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign en_out   = en_q[DEPTH-1];
    assign clr_out  = clr_q[DEPTH-1];
    assign data_out = data_q[DEPTH-1];
  end

endmodule

// File: rtl/array_eyeriss_feeder.sv
// Upstream sequencer for a HEIGHT x WIDTH Eyeriss-style PE array.
//   start, num_vec          : pass start (IDLE only) and ifm vector count
//   w_valid/w_ready/w_data  : weight vector stream, one word per column
//   s_valid/s_ready/s_data  : ifm vector stream, one word per row
//   en_i/clr_i/ifm          : per-row skewed ifm controls and data
//   en_w/clr_w/wght         : per-column skewed weight controls and data
//   en_o/clr_o              : per-column ofm drain controls
//   busy, done              : pass in progress, one-cycle end pulse
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | one cycle of clr tokens into every row/column root
// LOAD_W | accept exactly HEIGHT weight vectors
// STREAM | accept num_vec ifm vectors
// DRAIN  | DRAIN_LEN cycles with no injection, skew lines flush
// OUT    | diagonal en_o wave, OUT_LEN cycles
// DONE   | done pulse, back to IDLE
module array_eyeriss_feeder
  import array_eyeriss_pkg::*;
#(
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [CWIDTH-1:0]                   num_vec,
  input  logic                                w_valid,
  output logic                                w_ready,
  input  logic signed [WIDTH-1:0][IWIDTH-1:0] w_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic signed [HEIGHT-1:0][IWIDTH-1:0] s_data,
  output logic [HEIGHT-1:0]                   en_i,
  output logic [HEIGHT-1:0]                   clr_i,
  output logic signed [HEIGHT-1:0][IWIDTH-1:0] ifm,
  output logic [WIDTH-1:0]                    en_w,
  output logic [WIDTH-1:0]                    clr_w,
  output logic signed [WIDTH-1:0][IWIDTH-1:0] wght,
  output logic [WIDTH-1:0]                    en_o,
  output logic [WIDTH-1:0]                    clr_o,
  output logic                                busy,
  output logic                                done
);

  localparam int DRAIN_LEN = drain_len(HEIGHT, WIDTH);
  localparam int OUT_LEN   = out_len(HEIGHT, WIDTH);
  localparam int PW        = $clog2(HEIGHT + WIDTH + 1);

  feeder_state_e     state_q, state_d;
  logic [CWIDTH-1:0] vec_rem_q, vec_rem_d;
  logic [CWIDTH-1:0] num_vec_q, num_vec_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              w_ready_q, s_ready_q;
  logic              w_acc, s_acc, inj_clr, eo_root;
  logic [WIDTH-1:0]  eo_clr_unused, eo_data_unused;

  assign w_acc = w_valid && w_ready_q;
  assign s_acc = s_valid && s_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_rem_q <= '0;
      num_vec_q <= '0;
      phase_q   <= '0;
      w_ready_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_rem_q <= vec_rem_d;
      num_vec_q <= num_vec_d;
      phase_q   <= phase_d;
      // Ready is a registered decode of the next state, so it drops the
      // cycle after the final accept and cannot take an extra vector.
      w_ready_q <= (state_d == LOAD_W);
      s_ready_q <= (state_d == STREAM);
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_rem_d = vec_rem_q;
    num_vec_d = num_vec_q;
    phase_d   = phase_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_vec_d = num_vec;
          state_d   = CLR;
        end
      end
      CLR: begin
        vec_rem_d = CWIDTH'(HEIGHT);
        state_d   = LOAD_W;
      end
      LOAD_W: begin
        if (w_acc) begin
          vec_rem_d = vec_rem_q - CWIDTH'(1);
          if (vec_rem_q == CWIDTH'(1)) begin
            if (num_vec_q == '0) begin
              phase_d = PW'(DRAIN_LEN - 1);
              state_d = DRAIN;
            end else begin
              vec_rem_d = num_vec_q;
              state_d   = STREAM;
            end
          end
        end
      end
      STREAM: begin
        if (s_acc) begin
          vec_rem_d = vec_rem_q - CWIDTH'(1);
          if (vec_rem_q == CWIDTH'(1)) begin
            phase_d = PW'(DRAIN_LEN - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (phase_q == '0) begin
          phase_d = PW'(OUT_LEN - 1);
          state_d = OUT;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      OUT: begin
        if (phase_q == '0) state_d = DONE;
        else               phase_d = phase_q - PW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign w_ready = w_ready_q;
  assign s_ready = s_ready_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign inj_clr = (state_q == CLR);
  // Phase counts down from OUT_LEN-1; the first HEIGHT cycles of OUT are
  // those with phase >= WIDTH-1, which lets the last column finish exactly
  // on the final OUT cycle.
  assign eo_root = (state_q == OUT) && (phase_q >= PW'(WIDTH - 1));

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    skew_line #(.DEPTH(h + 1), .DWIDTH(IWIDTH)) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_in    (s_acc),
      .clr_in   (inj_clr),
      .data_in  (s_data[h]),
      .en_out   (en_i[h]),
      .clr_out  (clr_i[h]),
      .data_out (ifm[h])
    );
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    skew_line #(.DEPTH(w + 1), .DWIDTH(IWIDTH)) u_wline (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_in    (w_acc),
      .clr_in   (inj_clr),
      .data_in  (w_data[w]),
      .en_out   (en_w[w]),
      .clr_out  (clr_w[w]),
      .data_out (wght[w])
    );

    skew_line #(.DEPTH(w), .DWIDTH(0)) u_oline (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_in    (eo_root),
      .clr_in   (1'b0),
      .data_in  (1'b0),
      .en_out   (en_o[w]),
      .clr_out  (eo_clr_unused[w]),
      .data_out (eo_data_unused[w])
    );
  end

  // The ofm clear lands on column w at cycle w+1 after CLR, the same slot
  // as the weight clear, so it shares that line.
  assign clr_o = clr_w;

endmodule
